// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall controller: load-use, branch-operand and mul/div occupancy.
// Ports: clk/rst, ID/EX/MEM hazard fields in; PC/IF-ID/ID-EX/EX control and perf_stalls out.
module hazard_stall_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int PERF_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        id_op1,
  input  logic [3:0]        id_op2,
  input  logic              id_uses_op2,
  input  logic              id_is_branch,
  input  logic              id_is_muldiv,
  input  logic              branch_taken,
  input  logic [3:0]        ex_op1,
  input  logic [1:0]        ex_regwrite,
  input  logic              ex_memread,
  input  logic [3:0]        mem_op1,
  input  logic              mem_memread,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              exmem_bubble,
  output logic              muldiv_busy,
  output logic [PERF_W-1:0] perf_stalls
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 1);

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic lu, br1, br2, stall;
  logic op1_hit_ex, op2_hit_ex;
  logic busy_last;

  // Full 4-bit compares; R0 is treated like any other register.
  assign op1_hit_ex = (ex_op1 == id_op1);
  assign op2_hit_ex = id_uses_op2 && (ex_op1 == id_op2);

  assign lu  = ex_memread && (op1_hit_ex || op2_hit_ex);
  assign br1 = id_is_branch && (ex_regwrite != 2'b00) && op1_hit_ex;
  assign br2 = id_is_branch && mem_memread && (mem_op1 == id_op1);

  assign stall = lu || br1 || br2;

  // Final BUSY cycle: the result leaves EX, so EX is no longer held.
  assign busy_last = (cnt_q <= 4'd1);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (rst) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else if (state_q == BUSY) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if (busy_last) begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end else begin
        ex_hold      = 1'b1;
        exmem_bubble = 1'b1;
        cnt_d        = cnt_q - 4'd1;
      end
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = branch_taken && id_is_branch;
      if (id_is_muldiv) begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
    end
  end

  assign muldiv_busy = !rst && (state_q == BUSY);

  always_comb begin
    perf_d = perf_q;
    if (rst) begin
      perf_d = '0;
    end else if (!pc_write && !(&perf_q)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  assign perf_stalls = rst ? '0 : perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors, queued expectations.
// A negedge monitor pops and checks each cycle's outputs.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] id_op1, id_op2, ex_op1, mem_op1;
  logic       id_uses_op2, id_is_branch, id_is_muldiv, branch_taken;
  logic [1:0] ex_regwrite;
  logic       ex_memread, mem_memread;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        ex_hold, exmem_bubble, muldiv_busy;
  logic [15:0] perf_stalls;

  logic       p4_pcw, p4_ifw, p4_fl, p4_bub, p4_hold, p4_exb, p4_busy;
  logic [3:0] p4_perf;

  hazard_stall_unit #(.MULDIV_CYCLES(4), .PERF_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_op1(id_op1), .id_op2(id_op2), .id_uses_op2(id_uses_op2),
    .id_is_branch(id_is_branch), .id_is_muldiv(id_is_muldiv),
    .branch_taken(branch_taken),
    .ex_op1(ex_op1), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_op1(mem_op1), .mem_memread(mem_memread),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold),
    .exmem_bubble(exmem_bubble), .muldiv_busy(muldiv_busy),
    .perf_stalls(perf_stalls)
  );

  hazard_stall_unit #(.MULDIV_CYCLES(4), .PERF_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_op1(id_op1), .id_op2(id_op2), .id_uses_op2(id_uses_op2),
    .id_is_branch(id_is_branch), .id_is_muldiv(id_is_muldiv),
    .branch_taken(branch_taken),
    .ex_op1(ex_op1), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_op1(mem_op1), .mem_memread(mem_memread),
    .pc_write(p4_pcw), .ifid_write(p4_ifw), .ifid_flush(p4_fl),
    .idex_bubble(p4_bub), .ex_hold(p4_hold),
    .exmem_bubble(p4_exb), .muldiv_busy(p4_busy),
    .perf_stalls(p4_perf)
  );

  typedef struct {
    string       name;
    logic        pcw, ifw, fl, bub, hold, exb, busy;
    logic [15:0] perf;
    logic        chk4;
    logic [3:0]  perf4;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk1(string nm, string f, logic a, logic e);
    if (a !== e) begin
      $display("FAIL %s.%s got=%0b want=%0b", nm, f, a, e);
      n_bad++;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk1(e.name, "pc_write", pc_write, e.pcw);
      chk1(e.name, "ifid_write", ifid_write, e.ifw);
      chk1(e.name, "ifid_flush", ifid_flush, e.fl);
      chk1(e.name, "idex_bubble", idex_bubble, e.bub);
      chk1(e.name, "ex_hold", ex_hold, e.hold);
      chk1(e.name, "exmem_bubble", exmem_bubble, e.exb);
      chk1(e.name, "muldiv_busy", muldiv_busy, e.busy);
      if (perf_stalls !== e.perf) begin
        $display("FAIL %s.perf_stalls got=%0d want=%0d",
                 e.name, perf_stalls, e.perf);
        n_bad++;
      end
      if (e.chk4 && p4_perf !== e.perf4) begin
        $display("FAIL %s.perf4 got=%0d want=%0d",
                 e.name, p4_perf, e.perf4);
        n_bad++;
      end
    end
  end

  task automatic idle_in();
    rst = 0; id_op1 = 0; id_op2 = 0; id_uses_op2 = 0;
    id_is_branch = 0; id_is_muldiv = 0; branch_taken = 0;
    ex_op1 = 0; ex_regwrite = 0; ex_memread = 0;
    mem_op1 = 0; mem_memread = 0;
  endtask

  // Push one expectation for the inputs currently driven, then advance a cycle.
  // kind: 0 run, 1 stall, 2 busy-hold, 3 busy-last, 4 reset
  task automatic exp(string nm, int kind, logic fl, int perf,
                     logic chk4 = 0, int perf4 = 0);
    exp_t e;
    e.name = nm;
    e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0;
    e.hold = 0; e.exb = 0; e.busy = 0;
    case (kind)
      1: begin e.pcw = 0; e.ifw = 0; e.bub = 1; end
      2: begin e.pcw = 0; e.ifw = 0; e.hold = 1; e.exb = 1; e.busy = 1; end
      3: begin e.pcw = 0; e.ifw = 0; e.busy = 1; end
      default: ;
    endcase
    e.fl = fl;
    e.perf = 16'(perf);
    e.chk4 = chk4;
    e.perf4 = 4'(perf4);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    rst = 1;
    @(posedge clk);
    #1;
    exp("rst0", 4, 0, 0);
    exp("rst1", 4, 0, 0, 1, 0);
    idle_in();
    exp("idle", 0, 0, 0);
    ex_memread = 1; ex_op1 = 5; id_op1 = 5;
    exp("lu_op1", 1, 0, 0);
    idle_in(); id_op1 = 5;
    exp("lu_release", 0, 0, 1);
    idle_in(); ex_memread = 1; ex_op1 = 3; id_op2 = 3;
    exp("lu_op2_unused", 0, 0, 1);
    id_uses_op2 = 1;
    exp("lu_op2_used", 1, 0, 1);
    idle_in();
    exp("idle2", 0, 0, 2);
    id_is_branch = 1; id_op1 = 7; branch_taken = 1;
    ex_op1 = 7; ex_memread = 1; ex_regwrite = 2'b01;
    exp("br_ex_load", 1, 0, 2);
    ex_op1 = 0; ex_memread = 0; ex_regwrite = 0;
    mem_op1 = 7; mem_memread = 1;
    exp("br_mem_load", 1, 0, 3);
    mem_op1 = 0; mem_memread = 0;
    exp("br_taken", 0, 1, 4);
    idle_in();
    exp("flush_once", 0, 0, 4);
    id_is_branch = 1; id_op1 = 9; ex_op1 = 9; ex_regwrite = 2'b10;
    exp("br_alu", 1, 0, 4);
    ex_regwrite = 2'b00;
    exp("br_nowrite", 0, 0, 5);
    idle_in(); ex_memread = 1; id_is_muldiv = 1;
    exp("lu_r0_md", 1, 0, 5);
    idle_in(); id_is_muldiv = 1;
    exp("md_issue", 0, 0, 6);
    idle_in(); ex_memread = 1; id_is_branch = 1; branch_taken = 1;
    exp("busy3", 2, 0, 6);
    exp("busy2", 2, 0, 7);
    exp("busy1", 3, 0, 8);
    idle_in();
    exp("md_done", 0, 0, 9);
    id_is_muldiv = 1;
    exp("md2_issue", 0, 0, 9);
    exp("md2_b3", 2, 0, 9);
    exp("md2_b2", 2, 0, 10);
    exp("md2_b1", 3, 0, 11);
    exp("md3_issue", 0, 0, 12);
    id_is_muldiv = 0;
    exp("md3_b3", 2, 0, 12);
    rst = 1;
    exp("md3_rst", 4, 0, 0);
    rst = 0;
    exp("post_rst", 0, 0, 0, 1, 0);
    ex_memread = 1; ex_op1 = 2; id_op1 = 2;
    for (int i = 0; i < 20; i++) begin
      exp("sat", 1, 0, i, 1, (i > 15) ? 15 : i);
    end
    idle_in();
    exp("sat_hold", 0, 0, 20, 1, 15);
    begin
      int budget = 50;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        $display("FAIL drain timeout left=%0d", q.size());
        n_bad++;
      end
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
